// File: rtl/uart_tx.sv
// uart_tx -- asynchronous serial transmitter.
//
// Sends one DBIT-bit word per request as a frame made of a start bit (low),
// the data bits LSB first, and a stop phase (high) of SB_TICK ticks. Bit
// timing comes from an external 16x oversampling tick (s_tick). Each start or
// data bit lasts 16 ticks. The clock is never divided here.
//
// Parameters
//   DBIT     data bits per frame (default 8)
//   SB_TICK  stop phase length in s_ticks: 16 = 1, 24 = 1.5, 32 = 2 stop bits
//
// Ports
//   clk           system clock
//   reset_n       asynchronous active-low reset; aborts any frame in flight
//   s_tick        16x baud tick, one clk wide
//   tx_start      transmit request, only looked at while idle
//   din           data word, captured on the edge that accepts tx_start
//   tx            registered serial line, idles high
//   tx_busy       registered; high while a frame is on the line
//   tx_done_tick  one-clk pulse on the final stop tick

module uart_tx #(
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            s_tick,
   input  logic            tx_start,
   input  logic [DBIT-1:0] din,
   output logic            tx,
   output logic            tx_busy,
   output logic            tx_done_tick
);

   localparam int SW = $clog2(SB_TICK) + 1;
   localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

   localparam logic [SW-1:0] BIT_LAST  = SW'(15);
   localparam logic [SW-1:0] STOP_LAST = SW'(SB_TICK - 1);
   localparam logic [NW-1:0] N_LAST    = NW'(DBIT - 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t          state_reg, state_next;
   logic [SW-1:0]   s_cnt_reg, s_cnt_next;
   logic [NW-1:0]   n_cnt_reg, n_cnt_next;
   logic [DBIT-1:0] b_reg, b_next;
   logic            tx_reg, tx_next;
   logic            busy_reg, busy_next;
   logic            done;

   // State and datapath registers. Reset is asynchronous so the line goes
   // high immediately when a frame is aborted.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= IDLE;
         s_cnt_reg <= '0;
         n_cnt_reg <= '0;
         b_reg     <= '0;
         tx_reg    <= 1'b1;
         busy_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         s_cnt_reg <= s_cnt_next;
         n_cnt_reg <= n_cnt_next;
         b_reg     <= b_next;
         tx_reg    <= tx_next;
         busy_reg  <= busy_next;
      end
   end

   // Next-state and line-level logic. The line level is decided by the
   // current state and registered, so tx trails the state by one clk.
   always_comb begin
      state_next = state_reg;
      s_cnt_next = s_cnt_reg;
      n_cnt_next = n_cnt_reg;
      b_next     = b_reg;
      tx_next    = 1'b1;
      done       = 1'b0;

      case (state_reg)
         IDLE: begin
            tx_next = 1'b1;
            if (tx_start) begin
               b_next     = din;
               s_cnt_next = '0;
               state_next = START;
            end
         end

         START: begin
            tx_next = 1'b0;
            if (s_tick) begin
               if (s_cnt_reg == BIT_LAST) begin
                  s_cnt_next = '0;
                  n_cnt_next = '0;
                  state_next = DATA;
               end else begin
                  s_cnt_next = s_cnt_reg + SW'(1);
               end
            end
         end

         DATA: begin
            tx_next = b_reg[0];
            if (s_tick) begin
               if (s_cnt_reg == BIT_LAST) begin
                  s_cnt_next = '0;
                  b_next     = b_reg >> 1;
                  if (n_cnt_reg == N_LAST) begin
                     state_next = STOP;
                  end else begin
                     n_cnt_next = n_cnt_reg + NW'(1);
                  end
               end else begin
                  s_cnt_next = s_cnt_reg + SW'(1);
               end
            end
         end

         STOP: begin
            tx_next = 1'b1;
            if (s_tick) begin
               if (s_cnt_reg == STOP_LAST) begin
                  state_next = IDLE;
                  done       = 1'b1;
               end else begin
                  s_cnt_next = s_cnt_reg + SW'(1);
               end
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase

      // Busy rises together with the falling start edge on tx. It drops on
      // the edge that ends the done pulse, so it is already low in the first
      // idle cycle.
      busy_next = (state_reg != IDLE) && !done;
   end

   assign tx           = tx_reg;
   assign tx_busy      = busy_reg;
   assign tx_done_tick = done;

endmodule
